// File: rtl/ls_usb_pkg.sv
// Shared definitions for the low-speed USB line side: line states, TX FSM states,
// SYNC byte and the default bit-stuffing limit.
package ls_usb_pkg;

    // Line state packed as {dp, dm}
    typedef logic [1:0] line_t;

    localparam line_t LINE_J   = 2'b01;
    localparam line_t LINE_K   = 2'b10;
    localparam line_t LINE_SE0 = 2'b00;

    typedef enum logic [2:0] {
        IDLE,
        DATA,
        STUFF_CHK,
        EOP_SE0,
        EOP_J
    } tx_state_e;

    localparam logic [7:0] SYNC_BYTE           = 8'h80;
    localparam int         STUFF_LIMIT_DEFAULT = 6;

    function automatic line_t line_toggle(input line_t l);
        return (l == LINE_J) ? LINE_K : LINE_J;
    endfunction

endpackage

// File: rtl/ls_usb_bit_tick.sv
// Fractional phase-accumulator strobe: one tick per ACC_MOD/ACC_INC clocks on average.
// Synchronous clear restarts the phase so the first tick lands ceil(ACC_MOD/ACC_INC) clocks later.
module ls_usb_bit_tick #(
    parameter int ACC_INC = 3,
    parameter int ACC_MOD = 10
) (
    input  logic clk,
    input  logic rst,
    input  logic clr_i,
    output logic tick_o
);
    localparam int AW = $clog2(ACC_MOD + ACC_INC);

    logic [AW-1:0] acc_q, acc_d;
    logic [AW-1:0] sum;
    logic          wrap;

    assign sum  = acc_q + AW'(ACC_INC);
    assign wrap = (sum >= AW'(ACC_MOD));

    always_comb begin
        acc_d = wrap ? (sum - AW'(ACC_MOD)) : sum;
        if (clr_i) begin
            acc_d = '0;
        end
    end

    assign tick_o = wrap && !clr_i;

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

endmodule

// File: rtl/ls_usb_tx.sv
// Low-speed USB transmit serializer: LSB-first shift, bit stuffing, NRZI, EOP.
// Optional packet counter on pkt_cnt enabled by defining LS_USB_TX_PKT_CNT_EN.
module ls_usb_tx
    import ls_usb_pkg::*;
#(
    parameter int ACC_INC     = 3,
    parameter int ACC_MOD     = 10,
    parameter int STUFF_LIMIT = STUFF_LIMIT_DEFAULT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start_pkt,
    input  logic [7:0] sbyte,
    input  logic       last_pkt_byte,
    output logic       show_next,
    output logic       dp,
    output logic       dm,
    output logic       oe,
    output logic       busy,
    output logic [7:0] pkt_cnt
);
    localparam int OW = $clog2(STUFF_LIMIT + 1);

    tx_state_e     state_q, state_d;
    logic [7:0]    shreg_q, shreg_d;
    logic          last_q, last_d;
    logic [OW-1:0] ones_q, ones_d;
    logic [2:0]    bitcnt_q, bitcnt_d;
    line_t         line_q, line_d;
    logic          oe_q, oe_d;
    logic          busy_q, busy_d;
    logic          shnext_q, shnext_d;
    logic          clr_acc;
    logic          tick;
    logic          stuff_due;

    ls_usb_bit_tick #(
        .ACC_INC(ACC_INC),
        .ACC_MOD(ACC_MOD)
    ) u_tick (
        .clk    (clk),
        .rst    (rst),
        .clr_i  (clr_acc),
        .tick_o (tick)
    );

    assign stuff_due = (ones_q == OW'(STUFF_LIMIT));

    always_comb begin
        state_d  = state_q;
        shreg_d  = shreg_q;
        last_d   = last_q;
        ones_d   = ones_q;
        bitcnt_d = bitcnt_q;
        line_d   = line_q;
        oe_d     = oe_q;
        busy_d   = busy_q;
        shnext_d = 1'b0;
        clr_acc  = 1'b0;

        unique case (state_q)
            IDLE: begin
                line_d = LINE_J;
                oe_d   = 1'b0;
                busy_d = 1'b0;
                if (start_pkt) begin
                    shreg_d  = sbyte;
                    last_d   = last_pkt_byte;
                    shnext_d = 1'b1;
                    ones_d   = '0;
                    bitcnt_d = '0;
                    busy_d   = 1'b1;
                    oe_d     = 1'b1;
                    clr_acc  = 1'b1;
                    state_d  = DATA;
                end
            end

            DATA: begin
                if (tick) begin
                    if (stuff_due) begin
                        line_d = line_toggle(line_q);
                        ones_d = '0;
                    end else begin
                        if (shreg_q[0]) begin
                            ones_d = ones_q + OW'(1);
                        end else begin
                            line_d = line_toggle(line_q);
                            ones_d = '0;
                        end
                        shreg_d = shreg_q >> 1;
                        if (bitcnt_q == 3'd7) begin
                            bitcnt_d = '0;
                            if (last_q) begin
                                state_d = STUFF_CHK;
                            end else begin
                                shreg_d  = sbyte;
                                last_d   = last_pkt_byte;
                                shnext_d = 1'b1;
                            end
                        end else begin
                            bitcnt_d = bitcnt_q + 3'd1;
                        end
                    end
                end
            end

            // A trailing run of ones still owes its stuffed zero before SE0
            STUFF_CHK: begin
                bitcnt_d = '0;
                if (!stuff_due) begin
                    state_d = EOP_SE0;
                end else if (tick) begin
                    line_d  = line_toggle(line_q);
                    ones_d  = '0;
                    state_d = EOP_SE0;
                end
            end

            EOP_SE0: begin
                if (tick) begin
                    if (bitcnt_q == 3'd2) begin
                        line_d  = LINE_J;
                        state_d = EOP_J;
                    end else begin
                        line_d   = LINE_SE0;
                        bitcnt_d = bitcnt_q + 3'd1;
                    end
                end
            end

            EOP_J: begin
                if (tick) begin
                    oe_d    = 1'b0;
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end
            end

            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            last_q   <= 1'b0;
            ones_q   <= '0;
            bitcnt_q <= '0;
            line_q   <= LINE_J;
            oe_q     <= 1'b0;
            busy_q   <= 1'b0;
            shnext_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            last_q   <= last_d;
            ones_q   <= ones_d;
            bitcnt_q <= bitcnt_d;
            line_q   <= line_d;
            oe_q     <= oe_d;
            busy_q   <= busy_d;
            shnext_q <= shnext_d;
        end
    end

    always_ff @(posedge clk) begin
        shreg_q <= shreg_d;
    end

    assign dp        = line_q[1];
    assign dm        = line_q[0];
    assign oe        = oe_q;
    assign busy      = busy_q;
    assign show_next = shnext_q;

`ifdef LS_USB_TX_PKT_CNT_EN
    logic [7:0] pkt_cnt_q;
    logic       pkt_done;

    assign pkt_done = (state_q == EOP_J) && tick;

    always_ff @(posedge clk) begin
        if (rst) begin
            pkt_cnt_q <= 8'h00;
        end else if (pkt_done) begin
            pkt_cnt_q <= pkt_cnt_q + 8'h01;
        end
    end

    assign pkt_cnt = pkt_cnt_q;
`else
    assign pkt_cnt = 8'h00;
`endif

endmodule
